// File: rtl/rv32i_types.sv
// Shared RV32I core types: the machine word and the fetch-to-decode queue entry.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word inst;
    rv32i_word pc_next;
    logic      br_pred;
  } iq_entry_t;

  localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/instruction_queue.sv
// In-order instruction queue between fetch/branch-predict and decode/dispatch.
// Enqueued packets become visible the cycle after the enqueue edge; flush empties the queue.
module instruction_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   iq_valid,
  output logic                   iq_ready,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            inst_in,
  input  logic [31:0]            pc_next_in,
  input  logic                   br_pred_in,
  output logic                   dq_valid,
  input  logic                   dq_ready,
  output logic [31:0]            pc_out,
  output logic [31:0]            inst_out,
  output logic [31:0]            pc_next_out,
  output logic                   br_pred_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  iq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic      w_full;
  logic      w_empty;
  logic      w_enq;
  logic      w_deq;
  iq_entry_t w_wr_entry;
  iq_entry_t w_head_entry;

  // Ready/valid depend only on registered occupancy, so no combinational path
  // exists from dq_ready to iq_ready; a full queue frees a slot only next cycle.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_enq   = iq_valid && !w_full && !flush;
  assign w_deq   = dq_ready && !w_empty && !flush;

  assign w_wr_entry = '{pc: pc_in, inst: inst_in, pc_next: pc_next_in, br_pred: br_pred_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_ONE;
      if (w_deq) r_head <= r_head + PTR_ONE;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= w_wr_entry;
  end

  always_comb begin
    iq_ready     = !w_full;
    dq_valid     = !w_empty;
    count        = r_count;
    w_head_entry = r_mem[r_head];
    pc_out       = '0;
    inst_out     = '0;
    pc_next_out  = '0;
    br_pred_out  = 1'b0;
    if (!w_empty) begin
      pc_out      = w_head_entry.pc;
      inst_out    = w_head_entry.inst;
      pc_next_out = w_head_entry.pc_next;
      br_pred_out = w_head_entry.br_pred;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: vector table for single-cycle steps plus
// hand-written sequences for pointer wrap and asynchronous reset.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        iq_valid;
  logic        iq_ready;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic [31:0] pc_next_in;
  logic        br_pred_in;
  logic        dq_valid;
  logic        dq_ready;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [31:0] pc_next_out;
  logic        br_pred_out;
  logic [3:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iq_valid(iq_valid), .iq_ready(iq_ready),
    .pc_in(pc_in), .inst_in(inst_in), .pc_next_in(pc_next_in), .br_pred_in(br_pred_in),
    .dq_valid(dq_valid), .dq_ready(dq_ready),
    .pc_out(pc_out), .inst_out(inst_out), .pc_next_out(pc_next_out), .br_pred_out(br_pred_out),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, iv, dr;
    logic [31:0] pc, inst, pcn;
    logic        br;
    logic        e_irdy, e_dv;
    logic [31:0] e_pc, e_inst, e_pcn;
    logic        e_br;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] inst_f(input logic [31:0] pc);
    return 32'h0000_0013 | (pc << 20);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_v(input logic fl, input logic iv, input logic dr,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic e_irdy, input logic e_dv,
                       input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic [3:0] e_cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.dr = dr;
    v.pc = pc; v.inst = inst; v.pcn = pc + 32'd4; v.br = pc[2];
    v.e_irdy = e_irdy; v.e_dv = e_dv;
    v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_pcn = e_dv ? e_pc + 32'd4 : 32'd0;
    v.e_br = e_dv & e_pc[2];
    v.e_cnt = e_cnt;
    vt.push_back(v);
  endtask

  task automatic add_std(input logic fl, input logic iv, input logic dr, input logic [31:0] pc,
                         input logic e_irdy, input logic e_dv, input logic [31:0] e_pc,
                         input logic [3:0] e_cnt);
    add_v(fl, iv, dr, pc, inst_f(pc), e_irdy, e_dv, e_pc, e_dv ? inst_f(e_pc) : 32'd0, e_cnt);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic dr, input logic [31:0] pc,
                       input logic [31:0] inst);
    flush = fl; iq_valid = iv; dq_ready = dr;
    pc_in = pc; inst_in = inst; pc_next_in = pc + 32'd4; br_pred_in = pc[2];
  endtask

  task automatic check_head(input string nm, input logic e_dv, input logic [31:0] e_pc,
                            input logic [31:0] e_inst, input logic [31:0] e_pcn, input logic e_br);
    chk({nm, "_dq_valid"}, {31'd0, dq_valid}, {31'd0, e_dv});
    chk({nm, "_pc_out"}, pc_out, e_pc);
    chk({nm, "_inst_out"}, inst_out, e_inst);
    chk({nm, "_pc_next_out"}, pc_next_out, e_pcn);
    chk({nm, "_br_pred_out"}, {31'd0, br_pred_out}, {31'd0, e_br});
  endtask

  task automatic apply(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    drive(v.fl, v.iv, v.dr, v.pc, v.inst);
    @(posedge clk);
    #1;
    chk({nm, "_iq_ready"}, {31'd0, iq_ready}, {31'd0, v.e_irdy});
    chk({nm, "_count"}, {28'd0, count}, {28'd0, v.e_cnt});
    check_head(nm, v.e_dv, v.e_pc, v.e_inst, v.e_pcn, v.e_br);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Test 1: single packet, one-cycle visibility
    add_v(0, 1, 0, 32'h60, 32'h13, 1, 1, 32'h60, 32'h13, 4'd1);
    add_std(0, 0, 1, 32'h0, 1, 0, 32'h0, 4'd0);
    // Test 2: fill, refused 9th offer, drain in order
    for (int k = 0; k < 8; k++)
      add_std(0, 1, 0, 32'(4 * k), (k != 7), 1, 32'h0, 4'(k + 1));
    add_std(0, 1, 0, 32'h20, 0, 1, 32'h0, 4'd8);
    for (int j = 1; j <= 8; j++)
      add_std(0, 0, 1, 32'h0, 1, (j < 8), (j < 8) ? 32'(4 * j) : 32'h0, 4'(8 - j));
    // Test 3: dequeue while full does not open a slot the same cycle
    for (int k = 0; k < 8; k++)
      add_std(0, 1, 0, 32'h100 + 32'(4 * k), (k != 7), 1, 32'h100, 4'(k + 1));
    add_std(0, 1, 1, 32'h200, 1, 1, 32'h104, 4'd7);
    add_std(0, 1, 0, 32'h200, 0, 1, 32'h104, 4'd8);
    for (int j = 0; j < 8; j++) begin
      if (j >= 7)          e = 32'h0;
      else if (j + 1 < 7)  e = 32'h104 + 32'(4 * (j + 1));
      else                 e = 32'h200;
      add_std(0, 0, 1, 32'h0, 1, (j < 7), e, 4'(7 - j));
    end
    // Test 5: flush with simultaneous enqueue/dequeue requests
    for (int k = 0; k < 5; k++)
      add_std(0, 1, 0, 32'h300 + 32'(4 * k), 1, 1, 32'h300, 4'(k + 1));
    add_std(1, 1, 1, 32'h400, 1, 0, 32'h0, 4'd0);
    add_std(0, 1, 0, 32'h80, 1, 1, 32'h80, 4'd1);
    add_std(0, 0, 1, 32'h0, 1, 0, 32'h0, 4'd0);

    #12;
    rst_n = 1'b1;
    chk("reset_iq_ready", {31'd0, iq_ready}, 32'd1);
    chk("reset_count", {28'd0, count}, 32'd0);
    check_head("reset", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    foreach (vt[i]) apply(vt[i], i);

    // Test 4: continuous enqueue+dequeue at occupancy 3 across pointer wrap
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 32'h500 + 32'(4 * k), inst_f(32'h500 + 32'(4 * k)));
      @(posedge clk); #1;
    end
    chk("wrap_prefill_count", {28'd0, count}, 32'd3);
    for (int i = 0; i < 20; i++) begin
      e = 32'h500 + 32'(4 * i);
      drive(0, 1, 1, 32'h50C + 32'(4 * i), inst_f(32'h50C + 32'(4 * i)));
      #1;
      check_head($sformatf("wrap%0d", i), 1'b1, e, inst_f(e), e + 32'd4, e[2]);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_count", i), {28'd0, count}, 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      e = 32'h550 + 32'(4 * i);
      drive(0, 0, 1, 32'h0, 32'h0);
      #1;
      check_head($sformatf("wrap_drain%0d", i), 1'b1, e, inst_f(e), e + 32'd4, e[2]);
      @(posedge clk); #1;
    end
    chk("wrap_end_count", {28'd0, count}, 32'd0);
    chk("wrap_end_dq_valid", {31'd0, dq_valid}, 32'd0);

    // Test 6: asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 32'h700 + 32'(4 * k), inst_f(32'h700 + 32'(4 * k)));
      @(posedge clk); #1;
    end
    chk("arst_pre_count", {28'd0, count}, 32'd4);
    drive(0, 0, 0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_iq_ready", {31'd0, iq_ready}, 32'd1);
    chk("arst_count", {28'd0, count}, 32'd0);
    check_head("arst", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #3;
    rst_n = 1'b1;
    drive(0, 1, 0, 32'h800, inst_f(32'h800));
    @(posedge clk); #1;
    chk("arst_after_count", {28'd0, count}, 32'd1);
    check_head("arst_after", 1'b1, 32'h800, inst_f(32'h800), 32'h804, 1'b0);
    drive(0, 0, 1, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("arst_final_count", {28'd0, count}, 32'd0);
    check_head("arst_final", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
